// File: rtl/dpll_gear_ctrl.sv
// DPLL acquisition/tracking sequencer: open-loop calibration, then three loop-filter gears judged by dlf_out spread.
// Optional macro GEAR_RELOCK_EN: a wide-spread window after lock drops back to acquisition.
module dpll_gear_ctrl #(
   parameter int SETTLE_CYC = 64,
   parameter int WIN_LEN    = 256,
   parameter int MAX_WIN    = 16,
   parameter int ALPHA_ACQ  = 3,
   parameter int BETA_ACQ   = 4,
   parameter int ALPHA_MID  = 4,
   parameter int BETA_MID   = 6,
   parameter int ALPHA_TRK  = 5,
   parameter int BETA_TRK   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dlf_out,
   input  logic [7:0]  lock_tol,
   output logic [2:0]  alpha,
   output logic [3:0]  beta,
   output logic        open_loop,
   output logic        rst_l_dpd,
   output logic        locked,
   output logic        timeout,
   output logic [1:0]  gear
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int WW = $clog2(WIN_LEN);
   localparam int FW = $clog2(MAX_WIN + 1);

   typedef enum logic [2:0] {S_IDLE, S_CAL, S_ACQ, S_MID, S_TRK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cal_cnt, cal_n;
   logic [WW-1:0] win_cnt, win_n;
   logic [FW-1:0] fail_cnt, fail_n;
   logic          locked_n, timeout_n;
   logic [15:0]   min_v, max_v, lo, hi, spread;
   logic          in_gear, win_last, pass;
   logic [2:0]    alpha_n;
   logic [3:0]    beta_n;
   logic [1:0]    gear_n;
   logic          open_n;

   function automatic logic [15:0] umin(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [15:0] umax(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a : b;
   endfunction

   // Window extremes: the first sample of a window reseeds min/max
   always_comb begin
      in_gear  = (state == S_ACQ) || (state == S_MID) || (state == S_TRK);
      win_last = in_gear && (win_cnt == WW'(WIN_LEN - 1));
      lo       = (win_cnt == '0) ? dlf_out : umin(min_v, dlf_out);
      hi       = (win_cnt == '0) ? dlf_out : umax(max_v, dlf_out);
      spread   = hi - lo;
      pass     = (spread <= {8'd0, lock_tol});
   end

   always_comb begin
      state_n   = state;
      cal_n     = '0;
      win_n     = in_gear ? win_cnt + WW'(1) : '0;
      fail_n    = fail_cnt;
      locked_n  = locked;
      timeout_n = timeout;
      case (state)
         S_CAL: begin
            cal_n = cal_cnt + CW'(1);
            if (cal_cnt == CW'(SETTLE_CYC - 1)) begin
               state_n = S_ACQ;
               fail_n  = '0;
            end
         end
         S_ACQ, S_MID, S_TRK: begin
            if (win_last) begin
               if (state == S_TRK && locked) begin
`ifdef GEAR_RELOCK_EN
                  if (spread > {7'd0, lock_tol, 1'b0}) begin
                     locked_n = 1'b0;
                     state_n  = S_ACQ;
                     fail_n   = '0;
                  end
`endif
               end else if (pass) begin
                  fail_n = '0;
                  case (state)
                     S_ACQ:   state_n  = S_MID;
                     S_MID:   state_n  = S_TRK;
                     default: locked_n = 1'b1;
                  endcase
               end else if (fail_cnt == FW'(MAX_WIN - 1)) begin
                  timeout_n = 1'b1;
                  state_n   = S_CAL;
                  fail_n    = '0;
               end else begin
                  fail_n = fail_cnt + FW'(1);
               end
            end
         end
         default: ;
      endcase
      // A restart wins over any window evaluation in the same cycle
      if (start) begin
         state_n   = S_CAL;
         cal_n     = '0;
         win_n     = '0;
         fail_n    = '0;
         locked_n  = 1'b0;
         timeout_n = 1'b0;
      end
   end

   always_comb begin
      alpha_n = 3'(ALPHA_ACQ);
      beta_n  = 4'(BETA_ACQ);
      gear_n  = 2'd3;
      open_n  = 1'b1;
      case (state_n)
         S_ACQ: begin gear_n = 2'd0; open_n = 1'b0; end
         S_MID: begin gear_n = 2'd1; open_n = 1'b0; alpha_n = 3'(ALPHA_MID); beta_n = 4'(BETA_MID); end
         S_TRK: begin gear_n = 2'd2; open_n = 1'b0; alpha_n = 3'(ALPHA_TRK); beta_n = 4'(BETA_TRK); end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cal_cnt   <= '0;
         win_cnt   <= '0;
         fail_cnt  <= '0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
         alpha     <= 3'(ALPHA_ACQ);
         beta      <= 4'(BETA_ACQ);
         gear      <= 2'd3;
         open_loop <= 1'b1;
         rst_l_dpd <= 1'b1;
      end else begin
         state     <= state_n;
         cal_cnt   <= cal_n;
         win_cnt   <= win_n;
         fail_cnt  <= fail_n;
         locked    <= locked_n;
         timeout   <= timeout_n;
         alpha     <= alpha_n;
         beta      <= beta_n;
         gear      <= gear_n;
         open_loop <= open_n;
         rst_l_dpd <= open_n;
      end
   end

   always_ff @(posedge clk) begin
      min_v <= lo;
      max_v <= hi;
   end

endmodule
